// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler: two-stage sampling, per-channel edge capture,
// round-robin sharing onto one valid/ready event port. Optional timestamps via EDGE_ARB_TIMESTAMP_EN.
module edge_event_arbiter #(
  parameter int NCH  = 4,
  parameter int ID_W = 2,
  parameter int TS_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    pulse,
  input  logic [2*NCH-1:0]  mode,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [ID_W-1:0]   ev_id,
  output logic              ev_rise,
  output logic [NCH-1:0]    ovf,
  input  logic [NCH-1:0]    ovf_clr
`ifdef EDGE_ARB_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]   ev_ts
`endif
);

  localparam bit CFG_OK = (NCH >= 2) && (NCH <= 16) && ((2 ** ID_W) >= NCH) && (TS_W > 0);

  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("edge_event_arbiter: invalid NCH/ID_W/TS_W combination");
    end
  endgenerate

  logic [NCH-1:0]  r1, r2;
  logic [NCH-1:0]  pending, pend_rise;
  logic [ID_W-1:0] rr;

  logic [NCH-1:0]  rise_det, fall_det, qual, gmask, drop;
  logic [ID_W-1:0] grant;
  logic            found, slot_free, grant_vld;

`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] pend_ts [NCH];
`endif

  assign rise_det  = r1 & ~r2;
  assign fall_det  = ~r1 & r2;
  assign slot_free = !ev_valid || ev_ready;
  assign grant_vld = slot_free && found;

  always_comb begin
    qual = '0;
    for (int i = 0; i < NCH; i++) begin
      qual[i] = (rise_det[i] & mode[2*i]) | (fall_det[i] & mode[2*i+1]);
    end
  end

  // Rotating search: first pending channel at or after rr, modulo NCH.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int off = 0; off < NCH; off++) begin
      if (!found && pending[(int'(rr) + off) % NCH]) begin
        found = 1'b1;
        grant = ID_W'((int'(rr) + off) % NCH);
      end
    end
  end

  always_comb begin
    gmask = '0;
    if (grant_vld) gmask[grant] = 1'b1;
  end

  // A granted channel frees its slot this cycle, so a coincident edge re-captures instead of dropping.
  assign drop = qual & pending & ~gmask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1        <= '0;
      r2        <= '0;
      pending   <= '0;
      pend_rise <= '0;
      ovf       <= '0;
      rr        <= '0;
      ev_valid  <= 1'b0;
      ev_id     <= '0;
      ev_rise   <= 1'b0;
`ifdef EDGE_ARB_TIMESTAMP_EN
      ts_cnt    <= '0;
      ev_ts     <= '0;
      for (int i = 0; i < NCH; i++) pend_ts[i] <= '0;
`endif
    end else begin
      r1 <= pulse;
      r2 <= r1;
`ifdef EDGE_ARB_TIMESTAMP_EN
      ts_cnt <= ts_cnt + 1'b1;
`endif
      for (int i = 0; i < NCH; i++) begin
        if (qual[i] && !drop[i]) begin
          pending[i]   <= 1'b1;
          pend_rise[i] <= rise_det[i];
`ifdef EDGE_ARB_TIMESTAMP_EN
          pend_ts[i]   <= ts_cnt;
`endif
        end else if (gmask[i]) begin
          pending[i] <= 1'b0;
        end
      end

      ovf <= (ovf & ~ovf_clr) | drop;

      if (slot_free) begin
        if (found) begin
          ev_valid <= 1'b1;
          ev_id    <= grant;
          ev_rise  <= pend_rise[grant];
`ifdef EDGE_ARB_TIMESTAMP_EN
          ev_ts    <= pend_ts[grant];
`endif
          rr       <= (grant == ID_W'(NCH - 1)) ? '0 : grant + ID_W'(1);
        end else begin
          ev_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter; timestamp checks run only with EDGE_ARB_TIMESTAMP_EN.
module tb_edge_event_arbiter;

  localparam int NCH  = 4;
  localparam int ID_W = 2;
  localparam int TS_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  pulse;
  logic [2*NCH-1:0] mode;
  logic            ev_valid;
  logic            ev_ready;
  logic [ID_W-1:0] ev_id;
  logic            ev_rise;
  logic [NCH-1:0]  ovf;
  logic [NCH-1:0]  ovf_clr;
`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [TS_W-1:0] ev_ts;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  edge_event_arbiter #(.NCH(NCH), .ID_W(ID_W), .TS_W(TS_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse    (pulse),
    .mode     (mode),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_id    (ev_id),
    .ev_rise  (ev_rise),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
`ifdef EDGE_ARB_TIMESTAMP_EN
    ,
    .ev_ts    (ev_ts)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_ev(input string tag, input int id, input int rise);
    chk({tag, "_valid"}, int'(ev_valid), 1);
    chk({tag, "_id"}, int'(ev_id), id);
    chk({tag, "_rise"}, int'(ev_rise), rise);
  endtask

  initial begin
    rst = 1'b1; pulse = '0; mode = '0; ev_ready = 1'b1; ovf_clr = '0;
    step(2);
    chk("in_rst_valid", int'(ev_valid), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("post_rst_valid", int'(ev_valid), 0);
      chk("post_rst_ovf", int'(ovf), 0);
    end

    // single rising edge on ch2, fixed two-edge latency, one-cycle event
    mode = 8'h55; pulse = 4'b0100;
    step(2); chk("lat_early", int'(ev_valid), 0);
    step(1); chk_ev("rise2", 2, 1);
    step(1); chk("rise2_once", int'(ev_valid), 0);
    pulse = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step(1); chk("fall_ignored", int'(ev_valid), 0);
    end

    // round robin from rr=0
    rst = 1'b1; step(1); rst = 1'b0;
    pulse = 4'b1011;
    step(2); chk("rr_early", int'(ev_valid), 0);
    step(1); chk_ev("rr_a0", 0, 1);
    step(1); chk_ev("rr_a1", 1, 1);
    step(1); chk_ev("rr_a3", 3, 1);
    step(1); chk("rr_a_done", int'(ev_valid), 0);
    pulse = 4'b0000; step(3);
    chk("rr_fall_none", int'(ev_valid), 0);
    pulse = 4'b0011;
    step(3); chk_ev("rr_b0", 0, 1);
    step(1); chk_ev("rr_b1", 1, 1);
    step(1); chk("rr_b_done", int'(ev_valid), 0);
    pulse = 4'b0000; step(3);
    pulse = 4'b1001;
    step(3); chk_ev("rr_c3", 3, 1);
    step(1); chk_ev("rr_c0", 0, 1);
    pulse = 4'b0000; step(3);

    // mode off blocks capture
    mode = 8'h00; pulse = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step(1); chk("mode_off", int'(ev_valid), 0);
    end
    pulse = 4'b0000; step(3);
    chk("mode_off_fall", int'(ev_valid), 0);

    // pending events survive a mode change to off (rr=1 -> ch2 first)
    mode = 8'h55; ev_ready = 1'b0; pulse = 4'b0101;
    step(3); chk_ev("keep_2", 2, 1);
    mode = 8'h00;
    step(2); chk_ev("keep_hold", 2, 1);
    ev_ready = 1'b1;
    step(1); chk_ev("keep_0", 0, 1);
    step(1); chk("keep_done", int'(ev_valid), 0);
    pulse = 4'b0000; step(3);

    // stall, overflow, set-wins-over-clear, pending type retained
    mode = 8'h5D; ev_ready = 1'b0; pulse = 4'b0010;
    step(3); chk_ev("stall_1", 1, 1);
    step(1); pulse = 4'b0000;
    step(3);
    chk("stall_no_ovf", int'(ovf), 0);
    chk_ev("stall_hold", 1, 1);
    pulse = 4'b0010;
    step(3);
    chk("ovf_set", int'(ovf), 2);
    chk_ev("ovf_hold", 1, 1);
    pulse = 4'b0000; ovf_clr = 4'b0010;
    step(2); chk("ovf_set_wins", int'(ovf), 2);
    step(1); chk("ovf_cleared", int'(ovf), 0);
    ovf_clr = 4'b0000;
    ev_ready = 1'b1;
    step(1); chk_ev("pend_fall", 1, 0);
    step(1); chk("pend_fall_done", int'(ev_valid), 0);

    // reset mid-transfer drops presented and pending events
    mode = 8'h55; ev_ready = 1'b0; pulse = 4'b0001;
    step(3); chk_ev("pre_rst", 0, 1);
    pulse = 4'b1011;
    step(2);
    rst = 1'b1; pulse = 4'b0000;
    step(1);
    chk("rst_drop_valid", int'(ev_valid), 0);
    chk("rst_drop_ovf", int'(ovf), 0);
    rst = 1'b0; ev_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1); chk("rst_no_events", int'(ev_valid), 0);
    end

    // line high at reset release reads as a rising edge
    rst = 1'b1; pulse = 4'b0100;
    step(2); rst = 1'b0;
    step(2); chk("rel_early", int'(ev_valid), 0);
    step(1); chk_ev("rel_rise", 2, 1);
    pulse = 4'b0000; step(3);

`ifdef EDGE_ARB_TIMESTAMP_EN
    rst = 1'b1; step(1); rst = 1'b0;
    step(14); pulse = 4'b0001;
    step(2);  pulse = 4'b0011;
    step(1); chk_ev("ts_a", 0, 1); chk("ts_15", int'(ev_ts), 15);
    step(1); chk("ts_gap", int'(ev_valid), 0);
    step(1); chk_ev("ts_b", 1, 1); chk("ts_wrap_1", int'(ev_ts), 1);
    pulse = 4'b0000; step(2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
